mem_stage: RTL
==============

# mem_stage

Memory-access pipeline stage between `exe_stage` and `wb_stage`. It latches the EXE result bus and waits for the data-SRAM `data_ok` response of loads and stores issued from EXE. For loads, it extracts and sign/zero-extends the addressed byte, halfword or word. It buffers response data while WB back-pressures, then forwards the final result to WB and to the decode-stage bypass network.

## Interface
- Parameters: none. All widths are package constants.
- `clk`  in  1  — single clock.
- `resetn`  in  1  — asynchronous reset, active low.
- `ws_allowin`  in  1  — WB can accept this cycle.
- `ms_allowin`  out  1  — MS can accept this cycle.
- `es_to_ms_valid`  in  1  — EXE offers an instruction.
- `es_to_ms_bus`  in  `ES_TO_MS_BUS_WD` (80)  — EXE payload:
  - [31:0] pc
  - [63:32] alu_result (mem address)
  - [68:64] dest
  - [69] gr_we
  - [70] res_from_mem
  - [71] st_h, [72] st_b, [73] st_w
  - [74] ld_hu, [75] ld_h, [76] ld_bu, [77] ld_b, [78] ld_w
  - [79] mem_we
- `ms_to_ws_valid`  out  1  — MS offers an instruction to WB.
- `ms_to_ws_bus`  out  `MS_TO_WS_BUS_WD` (70)  — [31:0] pc, [63:32] final_result, [68:64] dest, [69] gr_we.
- `ms_forward`  out  `MS_FORWARD_WD` (72)  — [0] valid, [1] gr_we, [6:2] dest, [38:7] result, [70:39] pc, [71] blocking.
- `data_sram_data_ok`  in  1  — response for the oldest outstanding request.
- `data_sram_rdata`  in  32  — read data, valid with `data_ok`.

## Operation
- `ms_valid`, the payload register `ms_bus_r`, `rdata_buf[31:0]` and `buf_valid` are the only state.
- Accept: when `es_to_ms_valid && ms_allowin`, latch the bus and clear `buf_valid`. `ms_valid <= es_to_ms_valid` whenever `ms_allowin` is high.
- Mem op: `res_from_mem | mem_we`. A non-mem op has `ms_ready_go = 1`.
- A mem op has `ms_ready_go = buf_valid | data_sram_data_ok`.
- `data_ok` always belongs to the instruction currently held: it is counted only when `ms_valid && mem_op && !buf_valid`.
- If `data_ok` is counted but `ws_allowin = 0`: `rdata_buf <= rdata`, `buf_valid <= 1`.
- Effective data `rd = buf_valid ? rdata_buf : data_sram_rdata`.
- Load extraction uses `a = alu_result[1:0]`:
  - ld_w: `rd`.
  - ld_b / ld_bu: byte `rd[8a+7:8a]`, sign- or zero-extended to 32 bits.
  - ld_h / ld_hu: `a[1] ? rd[31:16] : rd[15:0]`, sign- or zero-extended.
  - Misaligned addresses are not checked; the stage uses the low bits as given.
- `final_result = res_from_mem ? load_data : alu_result`.
- Store responses are consumed and discarded; `gr_we` passes through unchanged.
- Forward `blocking` = `ms_valid && res_from_mem && !ms_ready_go`. Decode stalls on a dest match while `blocking` is set.

## Timing
- `ms_allowin = !ms_valid || (ms_ready_go && ws_allowin)`.
- `ms_to_ws_valid = ms_valid && ms_ready_go`.
- Latency:
  - Non-mem op: 1 cycle in MS.
  - Mem op: leaves in the cycle `data_ok` arrives if WB allows, otherwise on the first cycle WB allows after buffering.
- Reset values: `ms_valid = 0` and `buf_valid = 0`, so `ms_to_ws_valid = 0`, `ms_forward[0] = 0` and `ms_allowin = 1`. `ms_bus_r` and `rdata_buf` are cleared to 0.
- `data_ok` arriving with `ms_valid = 0`, or for a non-mem op, is ignored. The bench flags it as a protocol error.
- Simultaneous leave and accept: in the same cycle an old instruction can leave on `data_ok` while a new one is accepted. That `data_ok` is credited to the old instruction only.
- Reset mid-wait: the instruction is dropped and the buffer invalidated. A late `data_ok` after reset is ignored.
- Only one response can be pending per held instruction; `buf_valid` never sets twice.

## Configuration
- `MS_FWD_LOAD_EN` defined: `ms_forward[38:7]` carries `final_result`, including the extracted load data once `ms_ready_go`. `blocking` follows the rule in Operation.
- `MS_FWD_LOAD_EN` undefined: `blocking = ms_valid && res_from_mem`, regardless of data arrival, and the result field carries `alu_result`. Load results are then bypassed only from WB.

## Structure
- Shared package/header `myCPU.h`: `ES_TO_MS_BUS_WD`, `MS_TO_WS_BUS_WD`, `MS_FORWARD_WD` and the bus bit-position constants above.
- One sub-module: `load_extend`, combinational, inputs `rd`, `a` and the five ld flags, output 32-bit load data.

## Test plan
- ld_b, addr 0x1003, rdata 0x80FF_1234, `data_ok` 1 cycle after accept, WB open → WB receives 0xFFFF_FF80 one cycle after accept; `blocking` = 1 in the waiting cycle.
- ld_hu, addr 0x1002, rdata 0xBEEF_0000, `data_ok` arrives with `ws_allowin` = 0 for 3 cycles → `buf_valid` set, result 0x0000_BEEF delivered when `ws_allowin` rises; `ms_allowin` stays 0 until then.
- add, dest r5, result 0x1234 → exits next cycle; `ms_forward` = {valid 1, gr_we 1, dest 5, 0x1234, blocking 0}.
- st_w followed back-to-back by add → store holds MS until `data_ok`; add is accepted in the same cycle the store leaves; that `data_ok` is not credited to the add.
- Assert `resetn` low while ld_w is waiting, then send `data_ok` → all valids 0; no WB transfer; stray `data_ok` ignored.
- With `MS_FWD_LOAD_EN` undefined, ld_w whose data has already arrived → `blocking` still 1 and result field = address.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths and bus layouts for the memory-access stage.
// The packed struct field order fixes the bit positions of every bus.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 80;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_FORWARD_WD   = 72;

    typedef struct packed {
        logic        mem_we;        // [79]
        logic        ld_w;          // [78]
        logic        ld_b;          // [77]
        logic        ld_bu;         // [76]
        logic        ld_h;          // [75]
        logic        ld_hu;         // [74]
        logic        st_w;          // [73]
        logic        st_b;          // [72]
        logic        st_h;          // [71]
        logic        res_from_mem;  // [70]
        logic        gr_we;         // [69]
        logic [4:0]  dest;          // [68:64]
        logic [31:0] alu_result;    // [63:32]
        logic [31:0] pc;            // [31:0]
    } es_to_ms_bus_t;

    typedef struct packed {
        logic        gr_we;         // [69]
        logic [4:0]  dest;          // [68:64]
        logic [31:0] final_result;  // [63:32]
        logic [31:0] pc;            // [31:0]
    } ms_to_ws_bus_t;

    typedef struct packed {
        logic        blocking;      // [71]
        logic [31:0] pc;            // [70:39]
        logic [31:0] result;        // [38:7]
        logic [4:0]  dest;          // [6:2]
        logic        gr_we;         // [1]
        logic        valid;         // [0]
    } ms_forward_t;

endpackage

// File: rtl/mem_stage_if.sv
// Handshake, payload and data-SRAM response signals around the memory stage.
// slave = the stage itself, master = its environment (EXE, WB, SRAM, decode).
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [MS_FORWARD_WD-1:0]   ms_forward;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;

    modport slave (
        input  ws_allowin, es_to_ms_valid, es_to_ms_bus,
               data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_forward
    );

    modport master (
        output ws_allowin, es_to_ms_valid, es_to_ms_bus,
               data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_forward
    );

endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword/word of a load response and extends it.
// Misaligned addresses are not trapped; the low address bits are used as given.
module load_extend (
    input  logic [31:0] rd,
    input  logic [1:0]  a,
    input  logic        ld_w,
    input  logic        ld_b,
    input  logic        ld_bu,
    input  logic        ld_h,
    input  logic        ld_hu,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        byte_sel = rd[7:0];
        unique case (a)
            2'd0: byte_sel = rd[7:0];
            2'd1: byte_sel = rd[15:8];
            2'd2: byte_sel = rd[23:16];
            2'd3: byte_sel = rd[31:24];
        endcase
    end

    assign half_sel = a[1] ? rd[31:16] : rd[15:0];

    always_comb begin
        load_data = rd;
        if (ld_w)
            load_data = rd;
        else if (ld_b)
            load_data = {{24{byte_sel[7]}}, byte_sel};
        else if (ld_bu)
            load_data = {24'd0, byte_sel};
        else if (ld_h)
            load_data = {{16{half_sel[15]}}, half_sel};
        else if (ld_hu)
            load_data = {16'd0, half_sel};
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one EXE instruction, waits for its SRAM response,
// buffers it under WB back-pressure and forwards the result. Option: MS_FWD_LOAD_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    mem_stage_if.slave   ms_if
);

    logic          ms_valid;
    es_to_ms_bus_t ms_bus_r;
    logic [31:0]   rdata_buf;
    logic          buf_valid;

    logic          mem_op;
    logic          ms_ready_go;
    logic          data_ok_taken;
    logic [31:0]   rd;
    logic [31:0]   load_data;
    logic [31:0]   final_result;
    logic [31:0]   fwd_result;
    logic          blocking;
    ms_to_ws_bus_t ws_bus;
    ms_forward_t   fwd;
    logic          unused_st;

    assign mem_op        = ms_bus_r.res_from_mem | ms_bus_r.mem_we;
    assign ms_ready_go   = !mem_op || buf_valid || ms_if.data_sram_data_ok;
    // A response belongs to the held instruction only while it is still unanswered.
    assign data_ok_taken = ms_valid && mem_op && !buf_valid && ms_if.data_sram_data_ok;

    assign ms_if.ms_allowin     = !ms_valid || (ms_ready_go && ms_if.ws_allowin);
    assign ms_if.ms_to_ws_valid = ms_valid && ms_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            ms_valid  <= 1'b0;
            ms_bus_r  <= '0;
            // NOTE: the response buffer is a plain register, so it is cleared with the rest of the state.
            rdata_buf <= '0;
            buf_valid <= 1'b0;
        end else begin
            if (ms_if.ms_allowin) begin
                ms_valid  <= ms_if.es_to_ms_valid;
                buf_valid <= 1'b0;
            end else if (data_ok_taken && !ms_if.ws_allowin) begin
                rdata_buf <= ms_if.data_sram_rdata;
                buf_valid <= 1'b1;
            end
            if (ms_if.es_to_ms_valid && ms_if.ms_allowin)
                ms_bus_r <= es_to_ms_bus_t'(ms_if.es_to_ms_bus);
        end
    end

    assign rd = buf_valid ? rdata_buf : ms_if.data_sram_rdata;

    load_extend u_load_extend (
        .rd        (rd),
        .a         (ms_bus_r.alu_result[1:0]),
        .ld_w      (ms_bus_r.ld_w),
        .ld_b      (ms_bus_r.ld_b),
        .ld_bu     (ms_bus_r.ld_bu),
        .ld_h      (ms_bus_r.ld_h),
        .ld_hu     (ms_bus_r.ld_hu),
        .load_data (load_data)
    );

    assign final_result = ms_bus_r.res_from_mem ? load_data : ms_bus_r.alu_result;

`ifdef MS_FWD_LOAD_EN
    assign fwd_result = final_result;
    assign blocking   = ms_valid && ms_bus_r.res_from_mem && !ms_ready_go;
`else
    // Load data is bypassed only from WB, so a held load always stalls a dependent decode.
    assign fwd_result = ms_bus_r.alu_result;
    assign blocking   = ms_valid && ms_bus_r.res_from_mem;
`endif

    always_comb begin
        ws_bus.gr_we        = ms_bus_r.gr_we;
        ws_bus.dest         = ms_bus_r.dest;
        ws_bus.final_result = final_result;
        ws_bus.pc           = ms_bus_r.pc;

        fwd.blocking = blocking;
        fwd.pc       = ms_bus_r.pc;
        fwd.result   = fwd_result;
        fwd.dest     = ms_bus_r.dest;
        fwd.gr_we    = ms_bus_r.gr_we;
        fwd.valid    = ms_valid;
    end

    assign ms_if.ms_to_ws_bus = ws_bus;
    assign ms_if.ms_forward   = fwd;

    // Store width only matters to the SRAM request side in EXE.
    assign unused_st = ^{ms_bus_r.st_w, ms_bus_r.st_b, ms_bus_r.st_h};

endmodule
